operand_stack: RTL and testbench

LIFO operand stack with an attached ALU, sitting directly downstream of the stack-machine control unit. It consumes the decoded `push`, `pop` and `alu_op` strobes plus the immediate operand, and maintains stack storage and a depth count. It exposes top-of-stack (TOS) and next-on-stack (NOS) to the rest of the datapath. ALU operations pop two operands and push one result in a single cycle.

---
 rtl/operand_stack_pkg.sv | 28 ++
 rtl/operand_stack_alu.sv | 25 ++
 rtl/operand_stack.sv | 117 +++++++++++
 tb/tb_operand_stack.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg: opcode constants and action decode shared by the operand stack and control unit
package operand_stack_pkg;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;

    // Encoded as {pop, push}, matching the control unit's opcode field
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_POP,
        ACT_REPL,
        ACT_ALU
    } act_e;

    function automatic logic alu_active(input logic [3:0] op);
        return op != ALU_NONE && op >= ALU_ADD && op <= ALU_SLT;
    endfunction

endpackage

// File: rtl/operand_stack_alu.sv
// stack_alu: combinational two-operand ALU, result = a op b with a = NOS and b = TOS
module stack_alu
    import operand_stack_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result
);

    logic slt;

    always_comb begin
        slt    = $signed(a) < $signed(b);
        result = op == ALU_ADD ? a + b :
                 op == ALU_SUB ? a - b :
                 op == ALU_AND ? a & b :
                 op == ALU_OR  ? a | b :
                 op == ALU_XOR ? a ^ b :
                 op == ALU_SLT ? {{(DATA_W-1){1'b0}}, slt} : '0;
    end

endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack with single-cycle pop-two/push-one ALU and sticky error flags
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              push,
    input  logic              pop,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] tos,
    output logic [DATA_W-1:0] nos,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [AW-1:0]     tos_idx, nos_idx, push_idx;
    logic              has1, has2, is_full;
    logic [DATA_W-1:0] alu_res;
    act_e              act;

    always_comb begin
        tos_idx  = AW'(count_q - CW'(1));
        nos_idx  = AW'(count_q - CW'(2));
        push_idx = AW'(count_q);
        has1     = count_q != '0;
        has2     = count_q > CW'(1);
        is_full  = count_q == CW'(DEPTH);
    end

    // Outputs are gated by count because storage itself is never reset
    assign tos       = has1 ? mem_q[tos_idx] : '0;
    assign nos       = has2 ? mem_q[nos_idx] : '0;
    assign count     = count_q;
    assign empty     = !has1;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    stack_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (nos),
        .b      (tos),
        .op     (alu_op),
        .result (alu_res)
    );

    always_comb begin
        act = !op_valid                ? ACT_NONE :
              {pop, push} == OP_PUSH   ? ACT_PUSH :
              {pop, push} == OP_POP    ? ACT_POP  :
              (push && pop)            ? ACT_REPL :
              alu_active(alu_op)       ? ACT_ALU  : ACT_NONE;
    end

    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (act)
            ACT_PUSH: begin
                if (is_full) overflow_d = 1'b1;
                else begin
                    mem_d[push_idx] = push_data;
                    count_d         = count_q + CW'(1);
                end
            end
            ACT_POP: begin
                if (!has1) underflow_d = 1'b1;
                else count_d = count_q - CW'(1);
            end
            ACT_REPL: begin
                if (!has1) underflow_d = 1'b1;
                else mem_d[tos_idx] = push_data;
            end
            ACT_ALU: begin
                if (!has2) underflow_d = 1'b1;
                else begin
                    mem_d[nos_idx] = alu_res;
                    count_d        = count_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed and random stimulus against a queue-based LIFO model
module tb_operand_stack;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] push_data = 32'd0;
    logic [31:0] tos, nos;
    logic [4:0]  count;
    logic        empty, full, overflow, underflow;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    bit          movf, mudf;

    operand_stack #(.DATA_W(32), .DEPTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .push      (push),
        .pop       (pop),
        .alu_op    (alu_op),
        .push_data (push_data),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            3: return a + b;
            4: return a - b;
            5: return a & b;
            6: return a | b;
            7: return a ^ b;
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit v, input bit p, input bit o, input int a, input logic [31:0] d);
        logic [31:0] x, y;
        if (!v) return;
        if (p && !o) begin
            if (mq.size() == 16) movf = 1;
            else mq.push_back(d);
        end else if (p && o) begin
            if (mq.size() == 0) mudf = 1;
            else mq[mq.size()-1] = d;
        end else if (o) begin
            if (mq.size() == 0) mudf = 1;
            else void'(mq.pop_back());
        end else if (a >= 3 && a <= 8) begin
            if (mq.size() < 2) mudf = 1;
            else begin
                y = mq.pop_back();
                x = mq.pop_back();
                mq.push_back(ref_alu(a, x, y));
            end
        end
    endtask

    task automatic check_all(input string tag);
        int n = mq.size();
        check({tag, ".tos"}, tos, n >= 1 ? mq[n-1] : 32'd0);
        check({tag, ".nos"}, nos, n >= 2 ? mq[n-2] : 32'd0);
        check({tag, ".count"}, count, n);
        check({tag, ".empty"}, empty, n == 0);
        check({tag, ".full"}, full, n == 16);
        check({tag, ".ovf"}, overflow, movf);
        check({tag, ".udf"}, underflow, mudf);
    endtask

    task automatic do_op(input string tag, input bit v, input bit p, input bit o, input int a, input logic [31:0] d);
        @(negedge clock);
        op_valid  = v;
        push      = p;
        pop       = o;
        alu_op    = 4'(a);
        push_data = d;
        model_step(v, p, o, a, d);
        @(posedge clock);
        #1;
        op_valid = 0;
        check_all(tag);
    endtask

    // Reset is asserted between edges to show the clear is immediate
    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 0;
        #1;
        mq.delete();
        movf = 0;
        mudf = 0;
        check_all(tag);
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        logic [31:0] d;
        int r;
        bit v, p, o;
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1;

        do_op("push5", 1, 1, 0, 0, 32'd5);
        do_op("push7", 1, 1, 0, 0, 32'd7);
        check("pp.count", count, 2);
        check("pp.tos", tos, 7);
        check("pp.nos", nos, 5);
        do_op("sub", 1, 0, 0, 4, 0);
        check("sub.tos", tos, 32'hFFFF_FFFE);
        check("sub.count", count, 1);

        do_op("slt1a", 1, 1, 0, 0, 32'd3);
        do_op("slt1b", 1, 1, 0, 0, 32'd9);
        do_op("slt1", 1, 0, 0, 8, 0);
        check("slt1.tos", tos, 1);
        do_op("slt2a", 1, 1, 0, 0, 32'hFFFF_FFFF);
        do_op("slt2b", 1, 1, 0, 0, 32'd1);
        do_op("slt2", 1, 0, 0, 8, 0);
        check("slt2.tos", tos, 1);
        do_op("slt3a", 1, 1, 0, 0, 32'd1);
        do_op("slt3b", 1, 1, 0, 0, 32'hFFFF_FFFF);
        do_op("slt3", 1, 0, 0, 8, 0);
        check("slt3.tos", tos, 0);

        do_reset("rst_ovf");
        for (int i = 1; i <= 17; i++) do_op("fill", 1, 1, 0, 0, 32'(i));
        check("ovf.count", count, 16);
        check("ovf.full", full, 1);
        check("ovf.flag", overflow, 1);
        check("ovf.tos", tos, 16);

        do_reset("rst_udf");
        do_op("udf_pop", 1, 0, 1, 0, 0);
        do_op("udf_add", 1, 0, 0, 3, 0);
        check("udf.flag", underflow, 1);
        check("udf.count", count, 0);
        check("udf.tos", tos, 0);
        check("udf.ovf", overflow, 0);

        do_reset("rst_repl");
        do_op("r10", 1, 1, 0, 0, 32'd10);
        do_op("r20", 1, 1, 0, 0, 32'd20);
        do_op("repl", 1, 1, 1, 3, 32'd99);
        check("repl.tos", tos, 99);
        check("repl.nos", nos, 10);
        check("repl.count", count, 2);

        do_reset("rst_mid0");
        do_op("mid_udf", 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) do_op("mid_push", 1, 1, 0, 0, 32'(100 + i));
        check("mid.count4", count, 4);
        check("mid.udf1", underflow, 1);
        do_reset("rst_mid");
        check("mid.count0", count, 0);
        check("mid.udf0", underflow, 0);
        do_op("p42", 1, 1, 0, 0, 32'd42);
        check("p42.tos", tos, 42);
        check("p42.count", count, 1);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset("rnd_rst");
                continue;
            end
            v = $urandom_range(0, 9) != 0;
            r = $urandom_range(0, 99);
            p = r < 45 || (r >= 80 && r < 88);
            o = (r >= 45 && r < 60) || (r >= 80 && r < 88);
            d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            do_op("rnd", v, p, o, $urandom_range(0, 15), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
